playback_scheduler: RTL and testbench
=====================================

PLAYBACK_SCHEDULER -- requirements
Module: playback_scheduler

Interface
REQ-001 SHALL have parameter OVF_W, default 28, width of divider overflow and duration words.
REQ-002 SHALL have parameter GAP_CYCLES, default 2500000, silent clock cycles inserted between consecutive notes.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  one-cycle strobe qualifying cmd.
REQ-006 SHALL have port cmd  input  2  command: 00 mute toggle, 01 play/pause, 10 next song, 11 stop.
REQ-007 SHALL have port rom_div  input  OVF_W  note divider overflow from song ROM; 0 means rest.
REQ-008 SHALL have port rom_dur  input  OVF_W  note duration in clock cycles from song ROM.
REQ-009 SHALL have port rom_last  input  1  marks the final note of the song.
REQ-010 SHALL have port rom_addr  output  8  {song_sel, note_idx[6:0]} to song ROM.
REQ-011 SHALL have port div_ovf  output  OVF_W  overflow word to the clock divider.
REQ-012 SHALL have port tone_en  output  1  gates divider output onto the buzzer.
REQ-013 SHALL have port play_pause  output  1  high while in FETCH_A, FETCH_D, PLAY or GAP.
REQ-014 SHALL have port stop  output  1  high while in STOPPED.
REQ-015 SHALL have port musica_atual  output  1  current song select.
REQ-016 SHALL have port mute  output  1  mute flag.

Function
REQ-017 SHALL implement states STOPPED, FETCH_A, FETCH_D, PLAY, GAP, PAUSED.
REQ-018 SHALL drive tone_en = (state==PLAY) & !mute & (div_ovf!=0); low in every other state.
REQ-019 STOPPED: note_idx held 0; cmd 01 -> FETCH_A; cmd 10 -> toggle song_sel, stay STOPPED.
REQ-020 FETCH_A: rom_addr stable one cycle (ROM latency 1) -> FETCH_D.
REQ-021 FETCH_D: capture rom_div into div_ovf, load dur_cnt = max(rom_dur,1), latch rom_last -> PLAY.
REQ-022 PLAY: dur_cnt decrements each cycle; on cycle dur_cnt==1 -> GAP with gap_cnt = GAP_CYCLES.
REQ-023 GAP: gap_cnt decrements; at 1 -> if latched last or note_idx==127 then STOPPED with note_idx=0, else note_idx+1 and FETCH_A.
REQ-024 GAP_CYCLES=0 SHALL skip GAP (PLAY transitions directly as GAP exit would).
REQ-025 cmd 01 in PLAY or GAP -> PAUSED, counters frozen, return state saved; cmd 01 in PAUSED -> saved state, counting resumes next cycle.
REQ-026 cmd 01 in FETCH_A/FETCH_D SHALL be ignored.
REQ-027 cmd 11 in any state -> STOPPED next cycle, note_idx=0, dur_cnt=gap_cnt=0, div_ovf=0; song_sel and mute unchanged.
REQ-028 cmd 10 outside STOPPED SHALL be ignored.
REQ-029 cmd 00 in any state toggles mute; SHALL not alter state or counters.
REQ-030 cmd SHALL be ignored when cmd_valid low; at most one command per cycle, no queuing.
REQ-031 Counters SHALL be OVF_W bits unsigned, no wrap below 0.

Reset
REQ-032 reset_n low SHALL immediately force STOPPED, note_idx=0, song_sel=0, mute=0, div_ovf=0, dur_cnt=gap_cnt=0, tone_en=0, play_pause=0, stop=1.
REQ-033 reset_n asserted mid-note SHALL abort the note with no tone_en glitch after deassertion; resume requires cmd 01.

Verification
REQ-034 GAP_CYCLES=2, 3-note ROM dur 4,5,3, last on idx2, cmd 01 -> tone_en high 4,5,3 cycles separated by 2 low cycles, ends STOPPED, stop=1, rom_addr=0.
REQ-035 cmd 01 on cycle 2 of a dur=10 note, cmd 01 again 7 cycles later -> tone_en low 7 cycles, then high exactly 8 more cycles.
REQ-036 STOPPED, cmd 10 twice -> musica_atual 1 then 0, rom_addr[7] follows; cmd 10 during PLAY -> no change.
REQ-037 rom_div=0 note dur=6 -> tone_en low, play_pause high, note timing preserved; cmd 00 during a tone note -> tone_en drops next cycle, sequencing unaffected.
REQ-038 cmd 11 in GAP of idx5 -> STOPPED next cycle, rom_addr idx=0; rom_dur=0 note -> PLAY lasts 1 cycle.
REQ-039 reset_n pulsed low during PLAY of song 1 -> all outputs to REQ-032 values asynchronously, musica_atual=0.

Source files
------------

// File: rtl/playback_scheduler.sv
// playback_scheduler: steps through a song ROM one note at a time, timing each note and the silence between notes.
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   cmd_valid, cmd            one-cycle command strobe (00 mute, 01 play/pause, 10 next song, 11 stop)
//   rom_div, rom_dur, rom_last  song ROM data for rom_addr (one cycle of latency); rom_div 0 is a rest
//   rom_addr                  {song_sel, note_idx}
//   div_ovf, tone_en          overflow word and buzzer gate for the tone divider
//   play_pause, stop, musica_atual, mute  status
module playback_scheduler #(
  parameter int OVF_W      = 28,
  parameter int GAP_CYCLES = 2500000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  input  logic [OVF_W-1:0] rom_div,
  input  logic [OVF_W-1:0] rom_dur,
  input  logic             rom_last,
  output logic [7:0]       rom_addr,
  output logic [OVF_W-1:0] div_ovf,
  output logic             tone_en,
  output logic             play_pause,
  output logic             stop,
  output logic             musica_atual,
  output logic             mute
);
  typedef enum logic [2:0] {STOPPED, FETCH_A, FETCH_D, PLAY, GAP, PAUSED} state_t;
  localparam logic [OVF_W-1:0] ONE   = OVF_W'(1);
  localparam logic [OVF_W-1:0] GAP_L = OVF_W'(GAP_CYCLES);
  state_t state, state_n, ret, ret_n;
  logic [6:0] note_idx, idx_n;
  logic song_sel, song_n, mute_n, last, last_n, fin;
  logic [OVF_W-1:0] div_n, dur, dur_n, gap, gap_n;
  logic c_mute, c_play, c_next, c_stop;
  assign c_mute = cmd_valid && cmd == 2'b00;
  assign c_play = cmd_valid && cmd == 2'b01;
  assign c_next = cmd_valid && cmd == 2'b10;
  assign c_stop = cmd_valid && cmd == 2'b11;
  assign rom_addr     = {song_sel, note_idx};
  assign musica_atual = song_sel;
  assign tone_en      = state == PLAY && !mute && div_ovf != '0;
  assign play_pause   = state == FETCH_A || state == FETCH_D || state == PLAY || state == GAP;
  assign stop         = state == STOPPED;
  always_comb begin
    state_n = state;
    ret_n   = ret;
    idx_n   = note_idx;
    song_n  = song_sel;
    mute_n  = mute;
    last_n  = last;
    div_n   = div_ovf;
    dur_n   = dur;
    gap_n   = gap;
    fin     = 1'b0;
    case (state)
      STOPPED: begin
        idx_n   = '0;
        state_n = c_play ? FETCH_A : STOPPED;
        song_n  = c_next ? ~song_sel : song_sel;
      end
      FETCH_A: state_n = FETCH_D;
      FETCH_D: begin
        div_n   = rom_div;
        dur_n   = rom_dur == '0 ? ONE : rom_dur;
        last_n  = rom_last;
        state_n = PLAY;
      end
      PLAY: begin
        dur_n = dur == '0 ? '0 : dur - ONE;
        if (dur <= ONE) begin
          if (GAP_CYCLES == 0) begin
            fin = 1'b1;
          end else begin
            state_n = GAP;
            gap_n   = GAP_L;
          end
        end
      end
      GAP: begin
        gap_n = gap == '0 ? '0 : gap - ONE;
        fin   = gap <= ONE;
      end
      PAUSED: state_n = c_play ? ret : PAUSED;
      default: state_n = STOPPED;
    endcase
    if (fin && (last || &note_idx)) begin
      state_n = STOPPED;
      idx_n   = '0;
      div_n   = '0;
    end else if (fin) begin
      state_n = FETCH_A;
      idx_n   = note_idx + 7'd1;
    end
    // The cycle carrying the pause command still counts as played; the pause parks
    // on whatever PLAY/GAP step follows and is dropped if the note sequence moves on.
    if (c_play && (state == PLAY || state == GAP) && (state_n == PLAY || state_n == GAP)) begin
      ret_n   = state_n;
      state_n = PAUSED;
    end
    mute_n = c_mute ? ~mute : mute;
    if (c_stop) begin
      state_n = STOPPED;
      idx_n   = '0;
      div_n   = '0;
      dur_n   = '0;
      gap_n   = '0;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= STOPPED;
      ret      <= PLAY;
      note_idx <= '0;
      song_sel <= 1'b0;
      mute     <= 1'b0;
      last     <= 1'b0;
      div_ovf  <= '0;
      dur      <= '0;
      gap      <= '0;
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      note_idx <= idx_n;
      song_sel <= song_n;
      mute     <= mute_n;
      last     <= last_n;
      div_ovf  <= div_n;
      dur      <= dur_n;
      gap      <= gap_n;
    end
  end
endmodule

// File: tb/tb_playback_scheduler.sv
// tb_playback_scheduler: directed and randomized checks of playback_scheduler against a note-timeline model.
module tb_playback_scheduler;
  localparam int W = 28;
  localparam int G = 2;
  logic clock = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [W-1:0] rom_div, rom_dur, div_ovf;
  logic rom_last, tone_en, play_pause, stop, musica_atual, mute;
  logic [7:0] rom_addr;
  logic [W-1:0] mdiv [256];
  logic [W-1:0] mdur [256];
  logic mlast [256];
  int checks = 0, errors = 0;
  bit exp_mute = 1'b0;
  bit exp_t[$];
  always #5 clock = ~clock;
  always @(posedge clock) begin
    rom_div  <= mdiv[rom_addr];
    rom_dur  <= mdur[rom_addr];
    rom_last <= mlast[rom_addr];
  end
  playback_scheduler #(.OVF_W(W), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .rom_div(rom_div), .rom_dur(rom_dur), .rom_last(rom_last), .rom_addr(rom_addr),
    .div_ovf(div_ovf), .tone_en(tone_en), .play_pause(play_pause), .stop(stop),
    .musica_atual(musica_atual), .mute(mute)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [1:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask
  // Expected tone per cycle from the play command on: two fetch cycles, then for every
  // note max(dur,1) played cycles, G silent cycles and, unless it was the last, two fetch cycles.
  task automatic build(input int s, input bit m);
    exp_t.delete();
    exp_t.push_back(1'b0);
    exp_t.push_back(1'b0);
    for (int i = 0; i < 128; i++) begin
      int a;
      int d;
      a = s * 128 + i;
      d = mdur[a] == 0 ? 1 : int'(mdur[a]);
      repeat (d) exp_t.push_back(mdiv[a] != 0 && !m);
      repeat (G) exp_t.push_back(1'b0);
      if (mlast[a] || i == 127) break;
      exp_t.push_back(1'b0);
      exp_t.push_back(1'b0);
    end
  endtask
  task automatic play_song(input int s);
    build(s, exp_mute);
    send(2'b01);
    foreach (exp_t[k]) begin
      chk("tone", tone_en, exp_t[k]);
      chk("play_pause", play_pause, 1);
      @(negedge clock);
    end
    chk("end_stop", stop, 1);
    chk("end_addr", rom_addr, {s[0], 7'd0});
    chk("end_tone", tone_en, 0);
  endtask
  task automatic rand_song1(input int n);
    for (int i = 0; i < n; i++) begin
      mdur[128+i]  = W'($urandom_range(0, 7));
      mdiv[128+i]  = $urandom_range(0, 3) == 0 ? '0 : W'($urandom_range(1, 1000));
      mlast[128+i] = i == n - 1;
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mdiv[i] = '0;
      mdur[i] = '0;
      mlast[i] = 1'b0;
    end
    mdiv[0] = 100; mdur[0] = 4;
    mdiv[1] = 200; mdur[1] = 5;
    mdiv[2] = 300; mdur[2] = 3; mlast[2] = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_stop", stop, 1);
    chk("rst_pp", play_pause, 0);
    chk("rst_tone", tone_en, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_div", div_ovf, 0);
    chk("rst_mute", mute, 0);
    chk("rst_song", musica_atual, 0);
    reset_n = 1'b1;
    @(negedge clock);
    cmd = 2'b01;
    repeat (3) @(negedge clock);
    chk("invalid_cmd", stop, 1);
    send(2'b10);
    chk("song_a", musica_atual, 1);
    chk("song_a_addr", rom_addr[7], 1);
    send(2'b10);
    chk("song_b", musica_atual, 0);
    chk("song_b_addr", rom_addr[7], 0);
    play_song(0);
    send(2'b00);
    exp_mute = 1'b1;
    chk("mute_on", mute, 1);
    chk("mute_stopped", stop, 1);
    play_song(0);
    send(2'b00);
    exp_mute = 1'b0;
    chk("mute_off", mute, 0);
    send(2'b10);
    for (int r = 0; r < 4; r++) begin
      rand_song1($urandom_range(2, 6));
      if (r == 0) begin
        mdur[128] = '0; mdiv[128] = 77;
        mdur[129] = 6;  mdiv[129] = '0;
      end
      play_song(1);
    end
    send(2'b10);
    chk("song_back", musica_atual, 0);
    mdur[0] = 10;
    send(2'b01);
    send(2'b01);
    chk("fetch_ignore_pp", play_pause, 1);
    @(negedge clock);
    chk("pause_c1", tone_en, 1);
    @(negedge clock);
    chk("pause_c2", tone_en, 1);
    send(2'b01);
    for (int i = 0; i < 7; i++) begin
      chk("paused_tone", tone_en, 0);
      chk("paused_pp", play_pause, 0);
      chk("paused_stop", stop, 0);
      if (i < 6) @(negedge clock);
      else send(2'b01);
    end
    for (int k = 0; k < 8; k++) begin
      chk("resume_tone", tone_en, 1);
      if (k == 3) send(2'b10);
      else @(negedge clock);
    end
    chk("next_ignored", musica_atual, 0);
    chk("resume_gap", tone_en, 0);
    send(2'b11);
    chk("stop_state", stop, 1);
    chk("stop_div", div_ovf, 0);
    chk("stop_addr", rom_addr, 0);
    mdur[0] = 4;
    send(2'b01);
    @(negedge clock);
    @(negedge clock);
    chk("md_tone", tone_en, 1);
    send(2'b00);
    chk("md_drop", tone_en, 0);
    chk("md_pp", play_pause, 1);
    chk("md_mute", mute, 1);
    @(negedge clock);
    chk("md_still", play_pause, 1);
    send(2'b11);
    send(2'b00);
    chk("md_unmute", mute, 0);
    for (int i = 0; i < 7; i++) begin
      mdur[128+i] = 1;
      mdiv[128+i] = 50;
      mlast[128+i] = i == 6;
    end
    send(2'b10);
    send(2'b01);
    repeat (28) @(negedge clock);
    chk("gap5_addr", rom_addr, 8'h85);
    chk("gap5_tone", tone_en, 0);
    chk("gap5_pp", play_pause, 1);
    send(2'b11);
    chk("gap5_stop", stop, 1);
    chk("gap5_addr0", rom_addr, 8'h80);
    chk("gap5_div", div_ovf, 0);
    chk("gap5_song", musica_atual, 1);
    mdur[128] = 20;
    send(2'b01);
    @(negedge clock);
    @(negedge clock);
    chk("prereset_tone", tone_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_stop", stop, 1);
    chk("ar_pp", play_pause, 0);
    chk("ar_tone", tone_en, 0);
    chk("ar_song", musica_atual, 0);
    chk("ar_mute", mute, 0);
    chk("ar_addr", rom_addr, 0);
    chk("ar_div", div_ovf, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("post_tone", tone_en, 0);
      chk("post_stop", stop, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
